// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button-event FSM driving stopwatch counter enable/clear and display freeze
module stopwatch_ctrl #(
    parameter int HOLD_MS = 1000,
    parameter int HOLD_W  = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1k,
    input  logic       btn_start_pause,
    input  logic       btn_display_stop,
    input  logic       btn_clear,
    output logic       count_en,
    output logic       count_clr,
    output logic       display_hold,
    output logic       lap_strobe,
    output logic [1:0] state
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

    logic [1:0]        r_state;
    logic [2:0]        r_btn_q;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_display_hold;
    logic              r_lap_strobe;

    logic [2:0]        w_btn;
    logic [2:0]        w_press;
    logic              w_ds_release;
    logic              w_hold_run;
    logic              w_long;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [1:0]        w_state_nxt;
    logic              w_toggle;
    logic              w_display_nxt;

    // bit 0 start/pause, bit 1 display/stop, bit 2 clear
    assign w_btn        = {btn_clear, btn_display_stop, btn_start_pause};
    assign w_press      = w_btn & ~r_btn_q;
    assign w_ds_release = ~btn_display_stop & r_btn_q[1];

    // long-press counter only runs while display_stop is held in PAUSE; saturates at HOLD_MS
    assign w_hold_run = (r_state == PAUSE) & btn_display_stop;
    assign w_long     = w_hold_run & tick_1k & (r_hold_cnt == HOLD_W'(HOLD_MS - 1));
    assign w_hold_nxt = !w_hold_run ? '0 :
                        (tick_1k && r_hold_cnt != HOLD_W'(HOLD_MS)) ? r_hold_cnt + HOLD_W'(1) :
                        r_hold_cnt;

    // next-state and display toggle, priority clear > start > display_stop
    always_comb begin
        w_state_nxt = r_state;
        w_toggle    = 1'b0;
        if (w_press[2])
            w_state_nxt = CLEAR;
        else
            case (r_state)
                IDLE:  w_state_nxt = w_press[0] ? RUN : IDLE;
                RUN: begin
                    w_state_nxt = w_press[0] ? PAUSE : RUN;
                    w_toggle    = !w_press[0] && w_press[1];
                end
                PAUSE: begin
                    w_state_nxt = w_press[0] ? RUN : w_long ? CLEAR : PAUSE;
                    w_toggle    = !w_press[0] && !w_long && w_ds_release &&
                                  (r_hold_cnt < HOLD_W'(HOLD_MS));
                end
                default: w_state_nxt = IDLE;
            endcase
    end

    // entering CLEAR always unfreezes the display
    assign w_display_nxt = (w_state_nxt == CLEAR) ? 1'b0 : r_display_hold ^ w_toggle;

    // state, button history, hold counter and display registers; history resets to 1 so held buttons are not presses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_btn_q        <= 3'b111;
            r_hold_cnt     <= '0;
            r_display_hold <= 1'b0;
            r_lap_strobe   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_btn_q        <= w_btn;
            r_hold_cnt     <= w_hold_nxt;
            r_display_hold <= w_display_nxt;
            r_lap_strobe   <= w_display_nxt & ~r_display_hold;
        end
    end

    assign state        = r_state;
    assign count_en     = (r_state == RUN);
    assign count_clr    = (r_state == CLEAR);
    assign display_hold = r_display_hold;
    assign lap_strobe   = r_lap_strobe;
endmodule
